// File: rtl/player_physics.sv
// Per-frame sprite physics: position, speed and direction advance on each tick from the
// collision vector and a jump request. Define PLAYER_JUMP_BUFFER_EN to remember a press for BUF_DEPTH frames.
module player_physics #(
  parameter int POS_W      = 10,
  parameter int SPD_W      = 5,
  parameter int X_INIT     = 176,
  parameter int Y_INIT     = 99,
  parameter int X_SPEED    = 4,
  parameter int JUMP_SPEED = 17,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 15,
  parameter int GRID_LOG2  = 5,
  parameter int X_ORIGIN   = 144,
  parameter int Y_ORIGIN   = 35,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                       sim_clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       jump_r,
  input  logic [3:0]                 player_col,
  output logic [2*POS_W+2*SPD_W+1:0] player_state,
  output logic                       airborne,
  output logic [1:0]                 mode
);

  typedef enum logic [1:0] {
    GROUND = 2'b00,
    RISE   = 2'b01,
    FALL   = 2'b10
  } mode_t;

  localparam int CELL = 1 << GRID_LOG2;
  localparam logic [POS_W-1:0] CELL_P    = POS_W'(CELL);
  localparam logic [POS_W-1:0] CELL_MASK = POS_W'(CELL - 1);
  localparam logic [POS_W-1:0] X_STEP    = POS_W'(X_SPEED);
  localparam logic [POS_W-1:0] X_ORG     = POS_W'(X_ORIGIN);
  localparam logic [POS_W-1:0] Y_ORG     = POS_W'(Y_ORIGIN);
  localparam logic [SPD_W-1:0] JUMP_V    = SPD_W'(JUMP_SPEED);
  localparam logic [SPD_W-1:0] GRAV_V    = SPD_W'(GRAVITY);
  localparam logic [SPD_W-1:0] XSPD_V    = SPD_W'(X_SPEED);

  if (JUMP_SPEED >= (1 << SPD_W) || MAX_FALL >= (1 << SPD_W) || BUF_DEPTH < 1) begin : g_param_check
    $error("player_physics: JUMP_SPEED/MAX_FALL must fit SPD_W and BUF_DEPTH must be >= 1");
  end

  // Offset of a position inside its grid cell, measured from the grid origin.
  function automatic logic [POS_W-1:0] cell_off(input logic [POS_W-1:0] p,
                                                input logic [POS_W-1:0] org);
    return (p - org) & CELL_MASK;
  endfunction

  function automatic logic [POS_W-1:0] snap_before(input logic [POS_W-1:0] p,
                                                   input logic [POS_W-1:0] org);
    return p - cell_off(p, org) - POS_W'(1);
  endfunction

  function automatic logic [POS_W-1:0] snap_next(input logic [POS_W-1:0] p,
                                                 input logic [POS_W-1:0] org);
    return p + CELL_P - cell_off(p, org);
  endfunction

  function automatic logic [SPD_W-1:0] fall_speed(input logic [SPD_W-1:0] s);
    logic [SPD_W:0] t;
    t = {1'b0, s} + {1'b0, GRAV_V};
    if (t > (SPD_W+1)'(MAX_FALL))
      return SPD_W'(MAX_FALL);
    return t[SPD_W-1:0];
  endfunction

  mode_t            state;
  logic [POS_W-1:0] x_pos, y_pos;
  logic [SPD_W-1:0] x_speed, y_speed;
  logic             x_dir, y_dir;

  mode_t            mode_nxt;
  logic [POS_W-1:0] x_step, x_nxt, y_up, y_dn, y_nxt;
  logic [SPD_W-1:0] ys_nxt;
  logic             xdir_nxt, ydir_nxt;
  logic             jump_req, jump_taken, top_hit;

  assign x_step  = x_dir ? (x_pos + X_STEP) : (x_pos - X_STEP);
  assign y_up    = y_pos - POS_W'(y_speed);
  assign y_dn    = y_pos + POS_W'(y_speed);
  // A simultaneous floor contact suppresses the ceiling response.
  assign top_hit = player_col[3] & ~player_col[1];

  always_comb begin
    x_nxt      = x_step;
    xdir_nxt   = x_dir;
    y_nxt      = y_pos;
    ys_nxt     = y_speed;
    ydir_nxt   = y_dir;
    mode_nxt   = state;
    jump_taken = 1'b0;

    if (player_col[0] | player_col[2]) begin
      x_nxt    = x_dir ? snap_before(x_step, X_ORG) : snap_next(x_step, X_ORG);
      xdir_nxt = ~x_dir;
    end

    case (state)
      GROUND: begin
        if (jump_req) begin
          ys_nxt     = JUMP_V;
          ydir_nxt   = 1'b1;
          mode_nxt   = RISE;
          jump_taken = 1'b1;
        end else begin
          ys_nxt   = '0;
          ydir_nxt = 1'b0;
          if (!player_col[1])
            mode_nxt = FALL;
        end
      end
      RISE: begin
        y_nxt = y_up;
        if (top_hit) begin
          y_nxt    = snap_next(y_up, Y_ORG) - POS_W'(1);
          ys_nxt   = '0;
          ydir_nxt = 1'b0;
          mode_nxt = FALL;
        end else if (y_speed <= GRAV_V) begin
          ys_nxt   = '0;
          ydir_nxt = 1'b0;
          mode_nxt = FALL;
        end else begin
          ys_nxt = y_speed - GRAV_V;
        end
      end
      default: begin
        y_nxt    = y_dn;
        ydir_nxt = 1'b0;
        if (player_col[1]) begin
          y_nxt    = snap_before(y_dn, Y_ORG);
          ys_nxt   = '0;
          mode_nxt = GROUND;
        end else begin
          ys_nxt   = fall_speed(y_speed);
          mode_nxt = FALL;
        end
      end
    endcase
  end

`ifdef PLAYER_JUMP_BUFFER_EN
  localparam int BUF_W = $clog2(BUF_DEPTH + 1);
  logic [BUF_W-1:0] buf_cnt;

  assign jump_req = jump_r | (buf_cnt != '0);

  always_ff @(posedge sim_clk or posedge reset) begin
    if (reset)
      buf_cnt <= '0;
    else if (tick) begin
      if (jump_taken)
        buf_cnt <= '0;
      else if (jump_r)
        buf_cnt <= BUF_W'(BUF_DEPTH);
      else if (buf_cnt != '0)
        buf_cnt <= buf_cnt - BUF_W'(1);
    end
  end
`else
  assign jump_req = jump_r;
`endif

  // Frame register: everything commits on the tick edge.
  always_ff @(posedge sim_clk or posedge reset) begin
    if (reset) begin
      state    <= FALL;
      airborne <= 1'b1;
      x_pos    <= POS_W'(X_INIT);
      y_pos    <= POS_W'(Y_INIT);
      x_speed  <= XSPD_V;
      y_speed  <= '0;
      x_dir    <= 1'b1;
      y_dir    <= 1'b0;
    end else if (tick) begin
      state    <= mode_nxt;
      airborne <= (mode_nxt != GROUND);
      x_pos    <= x_nxt;
      y_pos    <= y_nxt;
      x_speed  <= XSPD_V;
      y_speed  <= ys_nxt;
      x_dir    <= xdir_nxt;
      y_dir    <= ydir_nxt;
    end
  end

  assign player_state = {x_pos, y_pos, x_speed, y_speed, x_dir, y_dir};
  assign mode         = state;

endmodule

// File: doc/player_physics.md
# player_physics

Parametrised per-frame physics engine for one sprite, replacing the fixed-constant player block. It advances position, speed and direction on each frame strobe from a 4-bit collision vector and a jump request. It adds an explicit movement state machine, terminal fall velocity, walk-off-edge detection, grid-aligned collision snapping with configurable cell size and origin, and an optional jump buffer. It sits between the collision detector and the renderer/game-logic, which both consume `player_state`.

## Interface
- `POS_W`, 10, position width (x and y)
- `SPD_W`, 5, speed width
- `X_INIT` / `Y_INIT`, 176 / 99, reset position
- `X_SPEED`, 4, constant horizontal speed
- `JUMP_SPEED`, 17, initial upward speed; must be < 2^SPD_W
- `GRAVITY`, 1, speed change per frame
- `MAX_FALL`, 15, terminal fall speed; must be < 2^SPD_W
- `GRID_LOG2`, 5, collision cell size = 2^GRID_LOG2 (CELL)
- `X_ORIGIN` / `Y_ORIGIN`, 144 / 35, grid origin in screen coordinates
- `BUF_DEPTH`, 4, jump-buffer length in frames (used only with the macro)

- `sim_clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `tick`  in  1  frame strobe; state advances only on edges where `tick`=1
- `jump_r`  in  1  jump request, sampled on tick edges
- `player_col`  in  4  collisions: [0] left, [1] bottom, [2] right, [3] top
- `player_state`  out  2·POS_W+2·SPD_W+2  {x_pos, y_pos, x_speed, y_speed, x_dir, y_dir}; x_dir 1=right, y_dir 1=up
- `airborne`  out  1  high when mode ≠ GROUND
- `mode`  out  2  FSM state: 00 GROUND, 01 RISE, 10 FALL

## Operation
- Reset values: x=X_INIT, y=Y_INIT, x_speed=X_SPEED, y_speed=0, x_dir=right, y_dir=down, mode=FALL, airborne=1, buffer=0.
- Horizontal motion on every tick: `xn = x ± X_SPEED`, using + when x_dir is right and − when left.
- Horizontal collision: if col[0]|col[2], snap x and flip x_dir.
  - Moving left: `x = xn + CELL − ((xn−X_ORIGIN) & (CELL−1))`.
  - Moving right: `x = xn − ((xn−X_ORIGIN) & (CELL−1)) − 1`.
- Vertical motion: position always moves by the pre-update y_speed.
- GROUND:
  - If a jump is requested: y_speed=JUMP_SPEED, y_dir=up, go to RISE.
  - Else if !col[1]: go to FALL (walked off an edge).
  - Else: y_speed stays 0.
- RISE:
  - `y −= y_speed`.
  - If y_speed ≤ GRAVITY: y_speed=0, y_dir=down, go to FALL.
  - Else: y_speed −= GRAVITY.
  - Top collision (col[3]): `y = y−y_speed + CELL−1−((y−y_speed−Y_ORIGIN) & (CELL−1))`, y_speed=0, y_dir=down, go to FALL.
- FALL:
  - `y += y_speed`, then y_speed = min(y_speed+GRAVITY, MAX_FALL).
  - Bottom collision (col[1]): `y = y+y_speed − ((y+y_speed−Y_ORIGIN) & (CELL−1)) − 1`, y_speed=0, go to GROUND.
- Priorities and boundary cases:
  - col[1] and col[3] together: bottom wins.
  - col[3] outside RISE: ignored.
  - col[1] during RISE: ignored.
  - A jump is never taken on the landing tick itself.
- Arithmetic: all position math is modulo 2^POS_W (wraps, no saturation). Speeds never exceed their limits, so no overflow occurs.

## Timing
- Every register updates on posedge `sim_clk` with `tick`=1; all outputs are registered.
- Results are visible one cycle after the tick edge. With `tick`=0, all state (including the buffer) holds.
- `reset` clears state immediately and asynchronously, including mid-jump or mid-tick. The first tick after deassertion uses the reset values.
- Back-to-back ticks (`tick` held high) are legal: one frame per clock.

## Configuration
- `PLAYER_JUMP_BUFFER_EN` defined:
  - A counter loads BUF_DEPTH on any tick with `jump_r`=1; otherwise it decrements toward 0 on each tick.
  - Jump requested = `jump_r` | (counter≠0).
  - The counter clears when a jump is taken.
- Undefined: jump requested = `jump_r` only. The counter is not instantiated, and a press on a non-GROUND tick is lost.

## Test plan
- Reset asserted mid-RISE, async between edges -> outputs immediately x=176, y=99, speeds 4/0, x_dir=1, y_dir=0, mode=10.
- Free fall from reset, no collisions, `tick` every cycle -> y = 99, 99, 100, 102, 105…; y_speed saturates at 15 and stays there.
- FALL, y=160, y_speed=6, col[1] -> y=162, y_speed=0, mode=00, airborne=0.
- GROUND at y=162, `jump_r` one tick -> y_speed=17, y_dir=1, y unchanged; after 17 further ticks, y=9, mode=10, y_speed=0.
- x=205, moving right, col[2] -> x=207, x_dir=0; next tick x=203.
- `jump_r` pulsed one tick while in FALL, col[1] on the next tick -> lands in GROUND.
  - With the macro: RISE on the tick after landing.
  - Without the macro: remains in GROUND.
